// File: rtl/wifi_descrambler_if.sv
// Port bundle for the bit-serial 802.11 descrambler: upstream FIFO pull side,
// frame control, and the descrambled bit stream towards the deparser.
interface wifi_descrambler_if #(
  parameter int LEN_W = 16
);
  // Handshake: rd_req asks the FIFO for one bit; the FIFO may drop it, and a
  // granted bit shows up as valid_in two cycles later. valid_out has no
  // backpressure: the deparser takes every bit strobed with valid_out.
  logic             start;
  logic [LEN_W-1:0] frame_len;
  logic             data_in;
  logic             valid_in;
  logic             rd_req;
  logic             data_out;
  logic             valid_out;
  logic [6:0]       seed_out;
  logic             seed_valid;
  logic             busy;
  logic             done;
  logic [1:0]       dbg_state;

  modport slave (
    input  start, frame_len, data_in, valid_in,
    output rd_req, data_out, valid_out, seed_out, seed_valid, busy, done,
           dbg_state
  );

  modport master (
    output start, frame_len, data_in, valid_in,
    input  rd_req, data_out, valid_out, seed_out, seed_valid, busy, done,
           dbg_state
  );
endinterface

// File: rtl/wifi_descrambler.sv
// 802.11 OFDM descrambler (x^7+x^4+1): recovers the seed from the first 7
// SERVICE bits, then descrambles the rest of a frame of programmed length.
module wifi_descrambler #(
  parameter int LEN_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  wifi_descrambler_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    DESC = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [6:0]       sr_q, sr_d;
  logic [6:0]       seed_q, seed_d;
  logic             seed_valid_q, seed_valid_d;
  logic             data_out_q, data_out_d;
  logic             valid_out_q, valid_out_d;
  logic             done_q, done_d;
  logic             req_d1_q, req_d2_q;

  logic             rd_req;
  logic [LEN_W:0]   in_flight;
  logic             last_bit;
  logic             fb;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    rx_cnt_d     = rx_cnt_q;
    sr_d         = sr_q;
    seed_d       = seed_q;
    seed_valid_d = seed_valid_q;
    data_out_d   = 1'b0;
    valid_out_d  = 1'b0;
    done_d       = 1'b0;

    // Bits already received plus requests still in the FIFO pipeline; a
    // dropped request stays counted until it ages out of req_d2.
    in_flight = {1'b0, rx_cnt_q} + (LEN_W+1)'(req_d1_q) + (LEN_W+1)'(req_d2_q);
    rd_req    = (state_q != IDLE) && (in_flight < {1'b0, len_q});
    last_bit  = ({1'b0, rx_cnt_q} + (LEN_W+1)'(1)) == {1'b0, len_q};
    fb        = sr_q[6] ^ sr_q[3];

    if (bus.start) begin
      // Also the abort path: in-flight bits will count towards the new frame.
      len_d        = bus.frame_len;
      rx_cnt_d     = '0;
      sr_d         = '0;
      seed_valid_d = 1'b0;
      if (bus.frame_len == '0) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = SEED;
      end
    end else if (bus.valid_in && (state_q != IDLE)) begin
      if (rx_cnt_q != len_q) rx_cnt_d = rx_cnt_q + 1'b1;
      valid_out_d = 1'b1;
      if (state_q == SEED) begin
        sr_d = {sr_q[5:0], bus.data_in};
        if (rx_cnt_q == LEN_W'(6)) begin
          seed_d       = {sr_q[5:0], bus.data_in};
          seed_valid_d = 1'b1;
          state_d      = DESC;
        end
      end else begin
        data_out_d = bus.data_in ^ fb;
        sr_d       = {sr_q[5:0], fb};
      end
      if (last_bit) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      rx_cnt_q     <= '0;
      sr_q         <= '0;
      seed_q       <= '0;
      seed_valid_q <= 1'b0;
      data_out_q   <= 1'b0;
      valid_out_q  <= 1'b0;
      done_q       <= 1'b0;
      req_d1_q     <= 1'b0;
      req_d2_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      rx_cnt_q     <= rx_cnt_d;
      sr_q         <= sr_d;
      seed_q       <= seed_d;
      seed_valid_q <= seed_valid_d;
      data_out_q   <= data_out_d;
      valid_out_q  <= valid_out_d;
      done_q       <= done_d;
      req_d1_q     <= rd_req;
      req_d2_q     <= req_d1_q;
    end
  end

  assign bus.rd_req     = rd_req;
  assign bus.data_out   = data_out_q;
  assign bus.valid_out  = valid_out_q;
  assign bus.seed_out   = seed_q;
  assign bus.seed_valid = seed_valid_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.dbg_state  = state_q;

endmodule
